demux_1x4_4bit_stream: RTL and testbench

Stream demultiplexer: accepts one 4-bit word per cycle on a single valid/ready input channel and steers it, by a 2-bit select, into one of four registered output lanes (a, b, c, d), each with its own valid/ready handshake. It is the fan-out counterpart of the 4-to-1, 4-bit selector. It sits where a single shared data path must be split back into four independent consumers. Each lane holds one word, so a stalled consumer blocks only its own lane.

---
 rtl/demux_1x4_4bit_stream.sv | 90 +++++++++
 tb/tb_demux_1x4_4bit_stream.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/demux_1x4_4bit_stream.sv
// 1-to-4 stream demultiplexer: one valid/ready input steered by in_sel into four
// single-entry registered output lanes, each with its own valid/ready handshake.

module demux_1x4_lane #(
    parameter int VEC_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [VEC_W-1:0] din,
    output logic             full,
    output logic [VEC_W-1:0] data
);
    // A push wins over a pop, so a simultaneous pop+push refills the lane with no bubble.
    always_ff @(posedge clk) begin
        if (rst) begin
            full <= 1'b0;
            data <= '0;
        end else if (push) begin
            full <= 1'b1;
            data <= din;
        end else if (pop) begin
            full <= 1'b0;
        end
    end
endmodule

module demux_1x4_4bit_stream (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [3:0] in_data,
    input  logic [1:0] in_sel,
    output logic [3:0] out_valid,
    input  logic [3:0] out_ready,
    output logic [3:0] out_a,
    output logic [3:0] out_b,
    output logic [3:0] out_c,
    output logic [3:0] out_d,
    output logic [7:0] xfer_cnt
);
    localparam int NUM_LANES = 4;
    localparam int VEC_W     = 4;

    typedef struct packed {
        logic [1:0]       sel;
        logic [VEC_W-1:0] data;
    } req_t;

    req_t                               req;
    logic                               xfer;
    logic [NUM_LANES-1:0]               full;
    logic [NUM_LANES-1:0]               push;
    logic [NUM_LANES-1:0]               pop;
    logic [NUM_LANES-1:0][VEC_W-1:0]    data;

    assign req = '{sel: in_sel, data: in_data};

    // Only the addressed lane can stall the input; other lanes never backpressure.
    assign in_ready = !rst && (!full[req.sel] || out_ready[req.sel]);
    assign xfer     = in_valid && in_ready;
    assign pop      = full & out_ready;

    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
        assign push[i] = xfer && (req.sel == 2'(i));

        demux_1x4_lane #(.VEC_W(VEC_W)) u_lane (
            .clk  (clk),
            .rst  (rst),
            .push (push[i]),
            .pop  (pop[i]),
            .din  (req.data),
            .full (full[i]),
            .data (data[i])
        );
    end

    assign out_valid = full;
    assign out_a     = data[0];
    assign out_b     = data[1];
    assign out_c     = data[2];
    assign out_d     = data[3];

    always_ff @(posedge clk) begin
        if (rst)       xfer_cnt <= 8'h00;
        else if (xfer) xfer_cnt <= xfer_cnt + 8'h01;
    end
endmodule

// File: tb/tb_demux_1x4_4bit_stream.sv
// Directed bench for demux_1x4_4bit_stream: per-cycle comparison against a lane
// occupancy model plus hand-computed literal checks along the test plan.

module tb_demux_1x4_4bit_stream;
    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] in_data;
    logic [1:0] in_sel;
    logic [3:0] out_valid;
    logic [3:0] out_ready;
    logic [3:0] out_a, out_b, out_c, out_d;
    logic [7:0] xfer_cnt;

    int checks = 0;
    int errors = 0;

    demux_1x4_4bit_stream dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_sel    (in_sel),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_a     (out_a),
        .out_b     (out_b),
        .out_c     (out_c),
        .out_d     (out_d),
        .xfer_cnt  (xfer_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: each lane either holds a word or is empty; count accepted words.
    bit       m_held [4];
    bit [3:0] m_word [4];
    int       m_count;
    bit       armed = 1'b0;

    function automatic bit model_ready();
        if (rst) return 1'b0;
        return !(m_held[in_sel] && !out_ready[in_sel]);
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            armed = 1'b1;
            m_count = 0;
            for (int i = 0; i < 4; i++) begin
                m_held[i] = 1'b0;
                m_word[i] = 4'h0;
            end
        end else if (armed) begin
            bit acc;
            acc = in_valid && model_ready();
            for (int i = 0; i < 4; i++)
                if (out_ready[i]) m_held[i] = 1'b0;
            if (acc) begin
                m_held[in_sel] = 1'b1;
                m_word[in_sel] = in_data;
                m_count = (m_count + 1) % 256;
            end
        end
    end

    always @(negedge clk) begin
        if (armed) begin
            logic [3:0] ev;
            for (int i = 0; i < 4; i++) ev[i] = m_held[i];
            chk("mdl_in_ready",  8'(in_ready),  8'(model_ready()));
            chk("mdl_out_valid", 8'(out_valid), 8'(ev));
            chk("mdl_out_a",     8'(out_a),     8'(m_word[0]));
            chk("mdl_out_b",     8'(out_b),     8'(m_word[1]));
            chk("mdl_out_c",     8'(out_c),     8'(m_word[2]));
            chk("mdl_out_d",     8'(out_d),     8'(m_word[3]));
            chk("mdl_xfer_cnt",  xfer_cnt,      8'(m_count));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b1; in_sel = 2'd2; in_data = 4'hF; out_ready = 4'b0000;
        tick(); tick();
        chk("rst_in_ready",  8'(in_ready),  8'h00);
        chk("rst_out_valid", 8'(out_valid), 8'h00);
        chk("rst_out_c",     8'(out_c),     8'h00);
        chk("rst_out_a",     8'(out_a),     8'h00);
        chk("rst_xfer_cnt",  xfer_cnt,      8'h00);
        rst = 1'b0;

        // Routing to each lane, consumers stalled
        for (int k = 0; k < 4; k++) begin
            in_valid = 1'b1; in_sel = 2'(k); in_data = 4'(k + 1);
            tick();
        end
        in_valid = 1'b0;
        chk("route_a",     8'(out_a),     8'h01);
        chk("route_b",     8'(out_b),     8'h02);
        chk("route_c",     8'(out_c),     8'h03);
        chk("route_d",     8'(out_d),     8'h04);
        chk("route_valid", 8'(out_valid), 8'h0F);
        chk("route_cnt",   xfer_cnt,      8'h04);

        // Drain lane d so the redirected word has somewhere to go
        out_ready = 4'b1000; tick(); out_ready = 4'b0000;
        chk("drain_d_valid", 8'(out_valid), 8'h07);

        in_valid = 1'b1; in_sel = 2'd1; in_data = 4'h9; #1;
        chk("bp_b_ready", 8'(in_ready), 8'h00);
        tick();
        chk("bp_b_hold", 8'(out_b), 8'h02);
        in_sel = 2'd3; #1;
        chk("bp_d_ready", 8'(in_ready), 8'h01);
        tick();
        in_valid = 1'b0;
        chk("bp_d_data", 8'(out_d), 8'h09);
        chk("bp_cnt",    xfer_cnt,  8'h05);

        // Same-lane pop+push: refill a with 5, then replace with 6
        in_valid = 1'b1; in_sel = 2'd0; in_data = 4'h5; out_ready = 4'b0001;
        tick();
        chk("pp_a5", 8'(out_a), 8'h05);
        in_data = 4'h6; #1;
        chk("pp_ready", 8'(in_ready), 8'h01);
        tick();
        chk("pp_a6",     8'(out_a),        8'h06);
        chk("pp_valid0", 8'(out_valid[0]), 8'h01);
        in_valid = 1'b0;
        tick();
        out_ready = 4'b0000;
        chk("pop_valid0", 8'(out_valid[0]), 8'h00);
        chk("pop_a_keep", 8'(out_a),        8'h06);

        // Streaming from a fresh count so the wrap lands on 8'h04
        rst = 1'b1; tick(); rst = 1'b0;
        out_ready = 4'b0100; in_valid = 1'b1; in_sel = 2'd2;
        for (int k = 0; k < 260; k++) begin
            in_data = 4'(k * 7 + 3); #1;
            if (!in_ready) begin
                errors++;
                $display("FAIL stream_ready word %0d got 0 expected 1", k);
            end
            checks++;
            tick();
            if (out_c !== 4'(k * 7 + 3) || out_valid[2] !== 1'b1) begin
                errors++;
                $display("FAIL stream_data word %0d got %h expected %h", k, out_c, 4'(k * 7 + 3));
            end
            checks++;
        end
        in_valid = 1'b0; out_ready = 4'b0000;
        chk("stream_cnt", xfer_cnt, 8'h04);

        // Reset mid-stream with lanes a and c full
        in_valid = 1'b1; in_sel = 2'd0; in_data = 4'hA; tick();
        in_sel = 2'd2; in_data = 4'hB; tick();
        chk("mid_valid_pre", 8'(out_valid), 8'h05);
        rst = 1'b1; in_sel = 2'd1; in_data = 4'hE; tick();
        chk("mid_valid", 8'(out_valid), 8'h00);
        chk("mid_a",     8'(out_a),     8'h00);
        chk("mid_c",     8'(out_c),     8'h00);
        chk("mid_cnt",   xfer_cnt,      8'h00);
        rst = 1'b0; in_sel = 2'd1; in_data = 4'h7; #1;
        chk("post_ready", 8'(in_ready), 8'h01);
        tick();
        in_valid = 1'b0;
        chk("post_b",     8'(out_b),     8'h07);
        chk("post_valid", 8'(out_valid), 8'h02);
        chk("post_cnt",   xfer_cnt,      8'h01);
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
